// File: rtl/cpu_multicycle_if.sv
// Shared memory port for the multi-cycle core: one req/ack handshake per transfer.
// master drives req/we/addr/wdata, slave returns rdata/ack.
interface cpu_multicycle_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Ports: clk, rst_n, bus (memory master), retire, halted, trap_cause, pc_dbg.
module cpu_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_multicycle_if.master  bus,
    output logic              retire,
    output logic              halted,
    output logic [1:0]        trap_cause,
    output logic [31:0]       pc_dbg
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0] wait_q;
    logic [31:0] rf_q [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wr_idx;
    logic [31:0] imm_sx, alu_res, wr_data;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j, r_ok, legal;
    logic        xfer_done, to_hit;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign imm_sx = {{16{ir_q[15]}}, ir_q[15:0]};

    assign is_r    = (op == 6'h00);
    assign is_addi = (op == 6'h08);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_j    = (op == 6'h02);
    assign r_ok    = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24)
                  || (funct == 6'h25) || (funct == 6'h2A);
    assign legal   = (is_r && r_ok) || is_addi || is_lw || is_sw || is_beq || is_j;

    assign wr_idx  = is_r ? rd : rt;
    assign wr_data = is_lw ? mdr_q : alu_q;

    assign xfer_done = bus.mem_req && bus.mem_ack;
    // Bus-error trap fires on the last permitted wait cycle that still has no ack.
    assign to_hit    = (TIMEOUT != 0) && bus.mem_req && !bus.mem_ack
                    && (wait_q == TO_LAST);

    always_comb begin
        alu_res = a_q + imm_sx;
        if (is_r) begin
            case (funct)
                6'h20:   alu_res = a_q + b_q;
                6'h22:   alu_res = a_q - b_q;
                6'h24:   alu_res = a_q & b_q;
                6'h25:   alu_res = a_q | b_q;
                6'h2A:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
                default: alu_res = a_q + b_q;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            S_FETCH: begin
                if (xfer_done) begin
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end else if (is_j) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw)  state_d = S_MEM;
                else if (is_beq)     state_d = S_FETCH;
                else                 state_d = S_WB;
            end
            S_MEM: begin
                if (xfer_done) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Outputs; bus outputs are gated by rst_n so they clear the moment reset asserts.
    always_comb begin
        bus.mem_req   = rst_n && ((state_q == S_FETCH) || (state_q == S_MEM));
        bus.mem_we    = bus.mem_req && (state_q == S_MEM) && is_sw;
        bus.mem_addr  = '0;
        if (bus.mem_req) begin
            bus.mem_addr = (state_q == S_MEM) ? alu_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
        end
        bus.mem_wdata = bus.mem_we ? b_q : 32'h0;
        retire        = rst_n && (((state_q == S_DECODE) && is_j)
                     || ((state_q == S_EXEC) && is_beq)
                     || ((state_q == S_MEM) && is_sw && xfer_done)
                     || (state_q == S_WB));
        halted        = (state_q == S_TRAP);
        trap_cause    = cause_q;
        pc_dbg        = pc_q;
    end

    // Wait-state counter, restarted by every ack and whenever no request is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= 32'h0;
        end else if (!bus.mem_req || bus.mem_ack) begin
            wait_q <= 32'h0;
        end else begin
            wait_q <= wait_q + 32'h1;
        end
    end

    // Datapath registers and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ir_q  <= 32'h0;
            a_q   <= 32'h0;
            b_q   <= 32'h0;
            alu_q <= 32'h0;
            mdr_q <= 32'h0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
        end else begin
            if ((state_q == S_FETCH) && xfer_done) begin
                ir_q <= bus.mem_rdata;
                pc_q <= pc_q + 32'd4;
            end
            if (state_q == S_DECODE) begin
                a_q <= rf_q[rs];
                b_q <= rf_q[rt];
                if (is_j) pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
            end
            if (state_q == S_EXEC) begin
                alu_q <= alu_res;
                if (is_beq && (a_q == b_q)) begin
                    pc_q <= pc_q + {imm_sx[29:0], 2'b00};
                end
            end
            if ((state_q == S_MEM) && xfer_done) mdr_q <= bus.mem_rdata;
            if ((state_q == S_WB) && (wr_idx != 5'd0)) rf_q[wr_idx] <= wr_data;
        end
    end

endmodule
